audio_uart_streamer: RTL and testbench



---
 rtl/audio_stream_pkg.sv | 23 ++
 rtl/audio_uart_streamer_tx.sv | 78 +++++++
 rtl/audio_uart_streamer.sv | 132 +++++++++++++
 tb/tb_audio_uart_streamer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the audio sample UART streamer.
package audio_stream_pkg;

   // Framer position within the three-byte frame.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_MSB  = 2'd2,
      ST_LSB  = 2'd3
   } framer_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Start + 8 data + stop.
   localparam int BITS_PER_BYTE = 10;
   localparam int BIT_CNT_W     = $clog2(BITS_PER_BYTE);

   // Width of a counter that runs 0 .. baud_div-1 (never narrower than 1 bit).
   function automatic int baud_cnt_width(input int baud_div);
      return (baud_div > 2) ? $clog2(baud_div) : 1;
   endfunction

endpackage

// File: rtl/audio_uart_streamer_tx.sv
// 8N1 byte serialiser: start bit 0, LSB-first data, stop bit 1.
// A new byte may be started in the byte_done cycle so bytes run back-to-back.
module uart_tx_byte
   import audio_stream_pkg::*;
#(
   parameter int BAUD_DIV = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       start,
   output logic       tx,
   output logic       byte_done,
   output logic       idle
);

   localparam int                   CNT_W     = baud_cnt_width(BAUD_DIV);
   localparam logic [CNT_W-1:0]     BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(BITS_PER_BYTE - 1);

   logic                 active_q, active_d;
   logic                 tx_q, tx_d;
   logic [9:0]           shift_q, shift_d;
   logic [CNT_W-1:0]     baud_q, baud_d;
   logic [BIT_CNT_W-1:0] bit_q, bit_d;

   assign byte_done = active_q && (bit_q == BIT_LAST) && (baud_q == BAUD_LAST);
   assign idle      = !active_q;
   assign tx        = tx_q;

   // Next-state: load a new byte, advance one bit per BAUD_DIV cycles, or finish.
   always_comb begin
      active_d = active_q;
      tx_d     = tx_q;
      shift_d  = shift_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      if (start && (!active_q || byte_done)) begin
         active_d = 1'b1;
         shift_d  = {1'b1, data, 1'b0};
         tx_d     = 1'b0;
         baud_d   = '0;
         bit_d    = '0;
      end else if (active_q) begin
         if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == BIT_LAST) begin
               active_d = 1'b0;
               tx_d     = 1'b1;
            end else begin
               shift_d = {1'b1, shift_q[9:1]};
               tx_d    = shift_d[0];
               bit_d   = bit_q + BIT_CNT_W'(1);
            end
         end else begin
            baud_d = baud_q + CNT_W'(1);
         end
      end
   end

   // Serialiser state; reset drives the line idle-high immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         tx_q     <= 1'b1;
         shift_q  <= '1;
         baud_q   <= '0;
         bit_q    <= '0;
      end else begin
         active_q <= active_d;
         tx_q     <= tx_d;
         shift_q  <= shift_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
      end
   end

endmodule

// File: rtl/audio_uart_streamer.sv
// Audio sample streamer: one-entry holding register, three-byte framer
// (sync, MSB, LSB) and a saturating counter of refused samples.
module audio_uart_streamer
   import audio_stream_pkg::*;
#(
   parameter int         BAUD_DIV  = 40,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int         DROP_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              ftdi_tx,
   output logic              busy,
   output logic [DROP_W-1:0] drop_count
);

   framer_state_t     state_q, state_d;
   logic [15:0]       frame_q, frame_d;
   logic [15:0]       hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              start_q, start_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic       accept;
   logic       take;
   logic       byte_done;
   logic       tx_idle;
   logic       tx_start;
   logic [7:0] tx_data;

   assign accept       = sample_valid && ready_q;
   assign sample_ready = ready_q;
   assign busy         = busy_q;
   assign drop_count   = drop_q;

   // Framer, holding register and drop counter next-state.
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      start_d     = 1'b0;
      drop_d      = drop_q;
      take        = 1'b0;

      case (state_q)
         ST_IDLE: if (hold_full_q) begin
            take    = 1'b1;
            state_d = ST_SYNC;
            start_d = 1'b1;
         end
         ST_SYNC: if (byte_done) state_d = ST_MSB;
         ST_MSB:  if (byte_done) state_d = ST_LSB;
         ST_LSB:  if (byte_done) begin
            if (hold_full_q) begin
               take    = 1'b1;
               state_d = ST_SYNC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (take) begin
         frame_d     = hold_q;
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_d      = sample_in;
         hold_full_d = 1'b1;
      end

      if (sample_valid && !ready_q && (drop_q != {DROP_W{1'b1}}))
         drop_d = drop_q + DROP_W'(1);

      ready_d = !hold_full_d;
      busy_d  = (state_d != ST_IDLE) || hold_full_d;
   end

   // Byte to send is chosen by the state being entered; follow-on bytes start
   // in the byte_done cycle so there is no gap within or between frames.
   always_comb begin
      tx_start = (start_q && tx_idle) || (byte_done && (state_d != ST_IDLE));
      case (state_d)
         ST_MSB:  tx_data = frame_q[15:8];
         ST_LSB:  tx_data = frame_q[7:0];
         default: tx_data = SYNC_BYTE;
      endcase
   end

   // Registered framer state and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         frame_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         drop_q      <= drop_d;
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx (
      .clk       (clk),
      .rst       (rst),
      .data      (tx_data),
      .start     (tx_start),
      .tx        (ftdi_tx),
      .byte_done (byte_done),
      .idle      (tx_idle)
   );

endmodule

// File: tb/tb_audio_uart_streamer.sv
// Self-checking bench for audio_uart_streamer at BAUD_DIV=4.
module tb_audio_uart_streamer;

   localparam int BD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic        ftdi_tx;
   logic        busy;
   logic [15:0] drop_count;

   logic [15:0] s_sample;
   logic        s_valid;
   logic        s_ready;
   logic        s_tx;
   logic        s_busy;
   logic [3:0]  s_drop;

   always #5 clk = ~clk;

   audio_uart_streamer #(.BAUD_DIV(BD), .DROP_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .ftdi_tx      (ftdi_tx),
      .busy         (busy),
      .drop_count   (drop_count)
   );

   audio_uart_streamer #(.BAUD_DIV(BD), .DROP_W(4)) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (s_sample),
      .sample_valid (s_valid),
      .sample_ready (s_ready),
      .ftdi_tx      (s_tx),
      .busy         (s_busy),
      .drop_count   (s_drop)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   int         byte_starts[$];
   int         acc_count     = 0;
   int         last_acc_edge = 0;
   int         obs_drops     = 0;

   typedef struct {
      logic [15:0] sample;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
   } vec_t;
   vec_t vecs[4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard producer: every accepted sample expects sync, MSB, LSB.
   initial begin : sb_push
      forever begin
         @(negedge clk);
         if (!rst && sample_valid) begin
            if (sample_ready) begin
               exp_q.push_back(8'hA5);
               exp_q.push_back(sample_in[15:8]);
               exp_q.push_back(sample_in[7:0]);
               acc_count++;
               last_acc_edge = cyc + 1;
            end else begin
               obs_drops++;
            end
         end
      end
   end

   // UART monitor: mid-bit sampling, aborts a byte on reset.
   initial begin : monitor
      int         st;
      int         bitn;
      logic [7:0] b;
      logic       aborted;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst && ftdi_tx === 1'b0) begin
            st      = cyc;
            b       = 8'h00;
            aborted = 1'b0;
            for (int k = 1; k < 10 * BD; k++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               if ((k % BD) == (BD / 2)) begin
                  bitn = k / BD;
                  if (bitn == 0)
                     check("start_bit", 32'(ftdi_tx), 32'd0);
                  else if (bitn <= 8)
                     b[bitn-1] = ftdi_tx;
                  else
                     check("stop_bit", 32'(ftdi_tx), 32'd1);
               end
            end
            if (!aborted) begin
               byte_starts.push_back(st);
               rx_log.push_back(b);
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_byte actual=0x%0h required=none (cycle %0d)", b, cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (b !== e) begin
                     failures++;
                     $display("FAIL byte_pos actual=0x%0h required=0x%0h (cycle %0d)", b, e, cyc);
                  end
               end
            end
         end
      end
   end

   task automatic drive_one(input logic [15:0] s);
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_in    = s;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int fall_cyc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", budget);
      end
      fall_cyc = cyc;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      int acc0;
      int fall;
      int n;

      vecs[0] = '{16'h1234, 8'hA5, 8'h12, 8'h34};
      vecs[1] = '{16'hA5A5, 8'hA5, 8'hA5, 8'hA5};
      vecs[2] = '{16'h0000, 8'hA5, 8'h00, 8'h00};
      vecs[3] = '{16'hFFFF, 8'hA5, 8'hFF, 8'hFF};

      rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
      s_valid = 1'b0; s_sample = 16'h4242;

      // Reset state
      repeat (3) @(posedge clk); #1;
      check("rst_tx", 32'(ftdi_tx), 32'd1);
      check("rst_ready", 32'(sample_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      check("rst_sat_drop", 32'(s_drop), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      check("ready_before_edge", 32'(sample_ready), 32'd0);
      @(posedge clk); #1;
      check("ready_after_edge", 32'(sample_ready), 32'd1);

      // Saturation on the narrow-counter instance: 20 refused cycles, then 30
      @(posedge clk); #1; s_valid = 1'b1;
      repeat (10) @(posedge clk); #1;
      check("sat_drop_8", 32'(s_drop), 32'd8);
      repeat (12) @(posedge clk); #1;
      check("sat_drop_20", 32'(s_drop), 32'hF);
      repeat (10) @(posedge clk); #1;
      check("sat_drop_hold", 32'(s_drop), 32'hF);
      s_valid = 1'b0;

      // Table-driven single frames
      for (int i = 0; i < 4; i++) begin
         rx_log.delete();
         byte_starts.delete();
         acc0 = acc_count;
         drive_one(vecs[i].sample);
         wait_idle(400, fall);
         check("accepted", 32'(acc_count - acc0), 32'd1);
         check("busy_fall", 32'(fall - last_acc_edge), 32'd122);
         check("rx_count", 32'(rx_log.size()), 32'd3);
         if (rx_log.size() == 3 && byte_starts.size() == 3) begin
            check("latency", 32'(byte_starts[0] - last_acc_edge), 32'd2);
            check("byte_gap", 32'(byte_starts[2] - byte_starts[0]), 32'(20 * BD));
            check("vec_b0", 32'(rx_log[0]), 32'(vecs[i].b0));
            check("vec_b1", 32'(rx_log[1]), 32'(vecs[i].b1));
            check("vec_b2", 32'(rx_log[2]), 32'(vecs[i].b2));
         end
         $display("vec %0d sample=%04h rx_bytes=%0d", i, vecs[i].sample, rx_log.size());
      end

      // Back-to-back frames
      rx_log.delete();
      byte_starts.delete();
      acc0 = acc_count;
      drive_one(16'h8001);
      repeat (10) @(posedge clk); #1;
      check("ready_mid_frame", 32'(sample_ready), 32'd1);
      drive_one(16'h7FFE);
      wait_idle(600, fall);
      check("b2b_accepted", 32'(acc_count - acc0), 32'd2);
      check("b2b_rx_count", 32'(rx_log.size()), 32'd6);
      if (byte_starts.size() == 6) begin
         for (int i = 1; i < 6; i++)
            check("b2b_spacing", 32'(byte_starts[i] - byte_starts[i-1]), 32'(10 * BD));
      end
      $display("b2b frames rx_bytes=%0d", rx_log.size());

      // Continuous valid for 300 cycles
      check("pre_cont_drop", 32'(drop_count), 32'd0);
      rx_log.delete();
      acc0 = acc_count;
      obs_drops = 0;
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_in = 16'h1000;
      repeat (300) begin
         @(posedge clk); #1;
         sample_in = sample_in + 16'd1;
      end
      sample_valid = 1'b0;
      check("cont_accepts", 32'(acc_count - acc0), 32'd4);
      check("cont_drop_exact", 32'(drop_count), 32'd296);
      check("cont_drop_obs", 32'(drop_count), 32'(obs_drops));
      wait_idle(2000, fall);
      check("cont_rx_count", 32'(rx_log.size()), 32'd12);
      check("cont_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("continuous accepts=%0d drops=%0d", acc_count - acc0, drop_count);

      // Reset in the middle of a byte
      drive_one(16'h5A3C);
      n = 0;
      while (ftdi_tx !== 1'b0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("tx_low_before_rst", 32'(ftdi_tx), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_mid_tx", 32'(ftdi_tx), 32'd1);
      check("rst_mid_ready", 32'(sample_ready), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_drop", 32'(drop_count), 32'd0);
      exp_q.delete();
      rx_log.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      check("rel_ready_before_edge", 32'(sample_ready), 32'd0);
      @(posedge clk); #1;
      check("rel_ready_after_edge", 32'(sample_ready), 32'd1);
      repeat (50) @(posedge clk); #1;
      check("no_partial_bytes", 32'(rx_log.size()), 32'd0);
      drive_one(16'hC3E1);
      wait_idle(400, fall);
      check("resync_rx_count", 32'(rx_log.size()), 32'd3);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("reset mid-byte resync rx_bytes=%0d", rx_log.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
